// File: rtl/muldiv_pkg.sv
// RV64M multiply/divide shared definitions.
// Op encodings (funct3), FSM states, signedness helpers.
package muldiv_pkg;

  localparam int XLEN_DEF = 64;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  function automatic logic a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV)  || (op == MD_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Conditional two's-complement negate: abs of a signed operand
// on input, sign fix-up of the raw result on output. x/neg in, y out.
module muldiv_operand_prep #(
  parameter int W = 64
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M mul/div unit beside the EX ALU.
// In: clk reset start kill op alu_in_A alu_in_B; out: busy done result stall.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] alu_in_A,
  input  logic [XLEN-1:0] alu_in_B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      op_q;
  logic            sa_q, sb_q, spec_q;
  logic [XLEN-1:0] opnd, lo, spec_res, res_q;
  logic [XLEN:0]   acc;

  logic            sa, sb;
  logic [XLEN-1:0] ma, mb;

  assign sa = a_signed(op) & alu_in_A[XLEN-1];
  assign sb = b_signed(op) & alu_in_B[XLEN-1];

  muldiv_operand_prep #(.W(XLEN)) u_prep_a (
    .x(alu_in_A), .neg(sa), .y(ma)
  );
  muldiv_operand_prep #(.W(XLEN)) u_prep_b (
    .x(alu_in_B), .neg(sb), .y(mb)
  );

  logic            dz, ovf, special;
  logic [XLEN-1:0] spec_val;

  assign dz  = (alu_in_B == '0);
  // sa already implies a signed op with a negative dividend
  assign ovf = sa & (alu_in_A == MIN) & (alu_in_B == '1);
  assign special = op[2] & (dz | ovf);

  // op[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    spec_val = op[1] ? {XLEN{1'b0}} : MIN;
    if (dz) spec_val = op[1] ? alu_in_A : {XLEN{1'b1}};
  end

  logic [XLEN:0]   sum, shl, diff, acc_nx;
  logic [XLEN-1:0] lo_nx;

  // Multiply: acc:lo is the product, lo shifts out multiplier bits.
  // Divide: acc is the partial remainder, lo shifts dividend out
  // and quotient bits in.
  always_comb begin
    sum  = acc + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    shl  = {acc[XLEN-1:0], lo[XLEN-1]};
    diff = shl - {1'b0, opnd};
    acc_nx = {1'b0, sum[XLEN:1]};
    lo_nx  = {sum[0], lo[XLEN-1:1]};
    if (op_q[2]) begin
      if (!diff[XLEN]) begin
        acc_nx = diff;
        lo_nx  = {lo[XLEN-2:0], 1'b1};
      end else begin
        acc_nx = shl;
        lo_nx  = {lo[XLEN-2:0], 1'b0};
      end
    end
  end

  logic [2*XLEN-1:0] fix_in, fix_out;
  logic              fix_neg;
  logic [XLEN-1:0]   res_sel;

  // remainder takes the dividend sign, everything else sA^sB
  always_comb begin
    fix_in  = {acc[XLEN-1:0], lo};
    fix_neg = sa_q ^ sb_q;
    if (op_q[2]) begin
      fix_in = {{XLEN{1'b0}}, (op_q[1] ? acc[XLEN-1:0] : lo)};
      if (op_q[1]) fix_neg = sa_q;
    end
  end

  muldiv_operand_prep #(.W(2*XLEN)) u_prep_res (
    .x(fix_in), .neg(fix_neg), .y(fix_out)
  );

  always_comb begin
    res_sel = fix_out[2*XLEN-1:XLEN];
    if (op_q[2] || (op_q == MD_MUL)) res_sel = fix_out[XLEN-1:0];
    if (spec_q) res_sel = spec_res;
  end

  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_FIN) & ~kill;
  assign result = done ? res_sel : res_q;
  assign stall  = start & ~done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      spec_q   <= 1'b0;
      opnd     <= '0;
      lo       <= '0;
      acc      <= '0;
      spec_res <= '0;
      res_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !kill) begin
            op_q     <= op;
            sa_q     <= sa;
            sb_q     <= sb;
            spec_q   <= special;
            spec_res <= spec_val;
            cnt      <= '0;
            acc      <= '0;
            lo       <= op[2] ? ma : mb;
            opnd     <= op[2] ? mb : ma;
            state    <= special ? ST_FIN : ST_CALC;
          end
        end
        ST_CALC: begin
          if (kill) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            acc <= acc_nx;
            lo  <= lo_nx;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN-1)) state <= ST_FIN;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          cnt   <= '0;
          if (!kill) res_q <= res_sel;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
